// File: rtl/xil_bram_tdp_bwe_1clk_if.sv
// xil_bram_tdp_bwe_1clk_if: request/response bundle for both ports of the dual-port RAM.
interface xil_bram_tdp_bwe_1clk_if #(
   parameter int ADR = 8,
   parameter int DAT = 18,
   parameter int NB  = 2
);
   logic [ADR-1:0] adra, adrb;
   logic           rena, renb, wena, wenb;
   logic [NB-1:0]  bena, benb;
   logic [DAT-1:0] wdaa, wdab, rdaa, rdab;
   logic           vlda, vldb, busy, coll;
   modport master (
      output adra, adrb, rena, renb, wena, wenb, bena, benb, wdaa, wdab,
      input  rdaa, rdab, vlda, vldb, busy, coll
   );
   modport slave (
      input  adra, adrb, rena, renb, wena, wenb, bena, benb, wdaa, wdab,
      output rdaa, rdab, vlda, vldb, busy, coll
   );
endinterface

// File: rtl/xil_bram_tdp_bwe_1clk.sv
// xil_bram_tdp_bwe_1clk: single-clock true dual-port RAM with byte-lane writes,
// DEL-cycle free-running read pipeline, selectable read-during-write and clear-on-reset sweep.
module xil_bram_tdp_bwe_1clk #(
   parameter int ADR        = 8,
   parameter int DAT        = 18,
   parameter int BW         = 9,
   parameter int DEP        = 256,
   parameter int DEL        = 1,
   parameter int RDW_MODE   = 0,
   parameter int CLR_ON_RST = 1
) (
   input logic                    clka,
   input logic                    rstb,
   xil_bram_tdp_bwe_1clk_if.slave bus
);
   localparam int NB = DAT / BW;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t         state_q, state_d;
   logic [ADR-1:0] ptr_q, ptr_d;
   logic           busy_q, busy_d, busy, coll_q;
   logic [DAT-1:0] mem_q [DEP];
   logic [ADR-1:0] adr [2];
   logic [NB-1:0]  ben [2];
   logic [DAT-1:0] wda [2], old [2], nw [2], rdv [2];
   logic [1:0]     ren, wen, en, inr, wt, wr, vin;
   logic [1:0]     v_q [DEL], vi [DEL];
   logic [DAT-1:0] d_q [2][DEL], di [2][DEL];

   assign adr  = '{bus.adra, bus.adrb};
   assign ben  = '{bus.bena, bus.benb};
   assign wda  = '{bus.wdaa, bus.wdab};
   assign ren  = {bus.renb, bus.rena};
   assign wen  = {bus.wenb, bus.wena};
   assign busy = busy_q | rstb;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      if (rstb) begin
         state_d = CLR_ON_RST != 0 ? CLEAR : IDLE;
         ptr_d   = '0;
         busy_d  = 1'b1;
      end else if (state_q == CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == ADR'(DEP - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clka) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
   end

   // nw is the word as it will read after this edge, with port A owning shared lanes
   always_comb begin
      en  = '0;
      inr = '0;
      wt  = '0;
      wr  = '0;
      vin = '0;
      old = '{default: '0};
      nw  = '{default: '0};
      rdv = '{default: '0};
      for (int p = 0; p < 2; p++) begin
         en[p]  = ren[p] & ~busy;
         inr[p] = int'(adr[p]) < DEP;
         wt[p]  = en[p] & wen[p] & (|ben[p]);
         wr[p]  = wt[p] & inr[p];
         old[p] = inr[p] ? mem_q[adr[p]] : '0;
      end
      for (int p = 0; p < 2; p++) begin
         nw[p] = old[p];
         for (int k = 1; k >= 0; k--)
            if (wr[k] && adr[k] == adr[p])
               for (int l = 0; l < NB; l++)
                  if (ben[k][l]) nw[p][l*BW +: BW] = wda[k][l*BW +: BW];
         rdv[p] = (RDW_MODE == 1 && wt[p]) ? nw[p] : old[p];
         vin[p] = en[p] & ~(RDW_MODE == 2 && wt[p]);
      end
   end

   always_ff @(posedge clka) begin
      if (state_q == CLEAR && !rstb) mem_q[ptr_q] <= '0;
      for (int k = 1; k >= 0; k--)
         if (wr[k])
            for (int l = 0; l < NB; l++)
               if (ben[k][l]) mem_q[adr[k]][l*BW +: BW] <= wda[k][l*BW +: BW];
   end

   always_comb begin
      vi = v_q;
      di = d_q;
      vi[0] = vin;
      for (int p = 0; p < 2; p++) di[p][0] = rdv[p];
      for (int i = 1; i < DEL; i++) begin
         vi[i] = v_q[i-1];
         for (int p = 0; p < 2; p++) di[p][i] = d_q[p][i-1];
      end
   end

   // data stages load only with a valid token, so the last stage holds rd between strobes
   always_ff @(posedge clka) begin
      if (rstb) begin
         coll_q <= 1'b0;
         for (int i = 0; i < DEL; i++) begin
            v_q[i] <= '0;
            for (int p = 0; p < 2; p++) d_q[p][i] <= '0;
         end
      end else begin
         coll_q <= wr[0] & wr[1] & (adr[0] == adr[1]);
         for (int i = 0; i < DEL; i++) begin
            v_q[i] <= vi[i];
            for (int p = 0; p < 2; p++)
               if (vi[i][p]) d_q[p][i] <= di[p][i];
         end
      end
   end

   assign bus.rdaa = d_q[0][DEL-1];
   assign bus.rdab = d_q[1][DEL-1];
   assign bus.vlda = v_q[DEL-1][0];
   assign bus.vldb = v_q[DEL-1][1];
   assign bus.busy = busy;
   assign bus.coll = coll_q;
endmodule

// File: tb/tb_xil_bram_tdp_bwe_1clk.sv
// tb_xil_bram_tdp_bwe_1clk: four RAM instances (read-first, write-first, no-change, and a
// short read-first RAM with unmapped addresses) share random stimulus; a scoreboard checks each.
module tb_xil_bram_tdp_bwe_1clk;
   typedef struct {logic [17:0] d; int due;} exp_t;
   localparam int BIG = 1 << 30;

   logic        clk = 1'b0;
   logic        rstb = 1'b1;
   logic        rst_seen = 1'b1;
   logic [3:0]  adra = '0, adrb = '0;
   logic        rena = 1'b0, renb = 1'b0, wena = 1'b0, wenb = 1'b0;
   logic [1:0]  bena = '0, benb = '0;
   logic [17:0] wdaa = '0, wdab = '0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          busy_until [4];
   logic [17:0] mem_m [4][16];
   logic [17:0] last [4][2];
   exp_t        sb [4][2][$];
   int          cq [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_seen <= rstb;

   function automatic int mode_of(int g);
      return g == 3 ? 0 : g;
   endfunction

   function automatic int dep_of(int g);
      return g == 3 ? 12 : 16;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : u
      xil_bram_tdp_bwe_1clk_if #(.ADR(4), .DAT(18), .NB(2)) bus ();
      assign bus.adra = adra;
      assign bus.adrb = adrb;
      assign bus.rena = rena;
      assign bus.renb = renb;
      assign bus.wena = wena;
      assign bus.wenb = wenb;
      assign bus.bena = bena;
      assign bus.benb = benb;
      assign bus.wdaa = wdaa;
      assign bus.wdab = wdab;
      xil_bram_tdp_bwe_1clk #(
         .ADR(4), .DAT(18), .BW(9), .DEP(g == 3 ? 12 : 16), .DEL(2),
         .RDW_MODE(g == 3 ? 0 : g), .CLR_ON_RST(1)
      ) dut (
         .clka(clk),
         .rstb(rstb),
         .bus (bus)
      );

      always @(negedge clk) begin : mon
         exp_t        e;
         logic        v, ce;
         logic [17:0] r;
         for (int p = 0; p < 2; p++) begin
            v = p == 1 ? bus.vldb : bus.vlda;
            r = p == 1 ? bus.rdab : bus.rdaa;
            if (rst_seen) begin
               checks++;
               if (v !== 1'b0 || r !== '0) begin
                  errors++;
                  $display("FAIL reset_out g%0d p%0d: vld=%b rd=%h, want 0/0", g, p, v, r);
               end
               last[g][p] = '0;
            end else begin
               while (sb[g][p].size() != 0 && sb[g][p][0].due < cyc) begin
                  errors++;
                  checks++;
                  $display("FAIL missing_vld g%0d p%0d: no vld at cycle %0d, want data %h",
                           g, p, sb[g][p][0].due, sb[g][p][0].d);
                  void'(sb[g][p].pop_front());
               end
               checks++;
               if (v) begin
                  if (sb[g][p].size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_vld g%0d p%0d: vld=1 rd=%h at cycle %0d, want vld=0",
                              g, p, r, cyc);
                  end else begin
                     e = sb[g][p].pop_front();
                     if (e.due != cyc || r !== e.d) begin
                        errors++;
                        $display("FAIL read g%0d p%0d: got %h at cycle %0d, want %h at cycle %0d",
                                 g, p, r, cyc, e.d, e.due);
                     end
                     last[g][p] = e.d;
                  end
               end else if (r !== last[g][p]) begin
                  errors++;
                  $display("FAIL hold g%0d p%0d: rd=%h while vld=0, want %h", g, p, r, last[g][p]);
               end
            end
         end
         ce = cq[g].size() != 0 && cq[g][0] == cyc;
         if (ce) void'(cq[g].pop_front());
         checks++;
         if (bus.coll !== ce) begin
            errors++;
            $display("FAIL coll g%0d: got %b at cycle %0d, want %b", g, bus.coll, cyc, ce);
         end
         checks++;
         if (bus.busy !== (rstb || cyc < busy_until[g])) begin
            errors++;
            $display("FAIL busy g%0d: got %b at cycle %0d, want %b", g, bus.busy, cyc,
                     rstb || cyc < busy_until[g]);
         end
      end
   end

   task automatic drive(input logic rst,
                        input logic ra, input logic wa, input logic [1:0] ba,
                        input logic [3:0] aa, input logic [17:0] da,
                        input logic rb, input logic wb, input logic [1:0] bb,
                        input logic [3:0] ab, input logic [17:0] db);
      logic [3:0]  ad [2];
      logic        rn [2], wrt [2], in_r [2];
      logic [1:0]  bn [2];
      logic [17:0] dt [2], old [2];
      @(posedge clk);
      #1;
      rstb = rst;
      {rena, wena, bena, adra, wdaa} = {ra, wa, ba, aa, da};
      {renb, wenb, benb, adrb, wdab} = {rb, wb, bb, ab, db};
      ad = '{aa, ab};
      rn = '{ra, rb};
      bn = '{ba, bb};
      dt = '{da, db};
      wrt = '{ra && wa && ba != 0, rb && wb && bb != 0};
      for (int g = 0; g < 4; g++) begin
         if (rst) begin
            for (int a = 0; a < 16; a++) mem_m[g][a] = '0;
            for (int p = 0; p < 2; p++)
               while (sb[g][p].size() != 0 && sb[g][p][$].due > cyc) void'(sb[g][p].pop_back());
            while (cq[g].size() != 0 && cq[g][$] > cyc) void'(cq[g].pop_back());
            busy_until[g] = BIG;
         end else begin
            if (busy_until[g] == BIG) busy_until[g] = cyc + dep_of(g);
            if (cyc >= busy_until[g]) begin
               for (int p = 0; p < 2; p++) begin
                  in_r[p] = int'(ad[p]) < dep_of(g);
                  old[p] = in_r[p] ? mem_m[g][ad[p]] : '0;
               end
               for (int k = 1; k >= 0; k--)
                  if (wrt[k] && in_r[k])
                     for (int l = 0; l < 2; l++)
                        if (bn[k][l]) mem_m[g][ad[k]][l*9 +: 9] = dt[k][l*9 +: 9];
               for (int p = 0; p < 2; p++)
                  if (rn[p] && !(wrt[p] && mode_of(g) == 2))
                     sb[g][p].push_back('{(wrt[p] && mode_of(g) == 1) ?
                                          (in_r[p] ? mem_m[g][ad[p]] : 18'h0) : old[p], cyc + 2});
               if (wrt[0] && wrt[1] && in_r[0] && ad[0] == ad[1]) cq[g].push_back(cyc + 1);
            end
         end
      end
   endtask

   task automatic rnd(input logic rst);
      logic [3:0] aa, ab;
      aa = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ab = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive(rst, $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), aa, 18'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), ab, 18'($urandom));
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int g = 0; g < 4; g++) begin
         busy_until[g] = BIG;
         last[g] = '{default: '0};
      end
      repeat (2) rnd(1'b1);
      repeat (16) rnd(1'b0);
      for (int a = 0; a < 16; a++) drive(1'b0, 1, 0, 0, 4'(a), 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1, 1, 2'b01, 4'd5, 18'h3FFFF, 0, 0, 0, 0, 0);
      drive(1'b0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd5, 0);
      drive(1'b0, 1, 1, 2'b11, 4'd3, 18'h12345, 1, 1, 2'b11, 4'd3, 18'h2ABCD);
      drive(1'b0, 1, 0, 0, 4'd3, 0, 1, 0, 0, 4'd3, 0);
      drive(1'b0, 1, 1, 2'b11, 4'd7, 18'h00011, 0, 0, 0, 0, 0);
      drive(1'b0, 1, 1, 2'b11, 4'd7, 18'h00022, 0, 0, 0, 0, 0);
      drive(1'b0, 1, 0, 0, 4'd7, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1, 1, 2'b10, 4'd9, 18'h3FFFF, 1, 0, 0, 4'd9, 0);
      idle(3);
      repeat (2) rnd(1'b1);
      repeat (8) rnd(1'b0);
      rnd(1'b1);
      repeat (20) rnd(1'b0);
      for (int a = 0; a < 16; a++)
         drive(1'b0, 1, 1, 2'b11, 4'(a), 18'($urandom), 1, 1, 2'b10, 4'(15 - a), 18'($urandom));
      for (int a = 0; a < 16; a++) drive(1'b0, 1, 0, 0, 4'(a), 0, 1, 0, 0, 4'(15 - a), 0);
      repeat (600) rnd(1'b0);
      idle(6);
      for (int g = 0; g < 4; g++)
         for (int p = 0; p < 2; p++) begin
            checks++;
            if (sb[g][p].size() != 0) begin
               errors++;
               $display("FAIL drain g%0d p%0d: %0d reads outstanding, want 0", g, p, sb[g][p].size());
            end
         end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/xil_bram_tdp_bwe_1clk.md
XIL_BRAM_TDP_BWE_1CLK -- requirements
Module: xil_bram_tdp_bwe_1clk

Interface
REQ-001 Parameter ADR, 8, address width.
REQ-002 Parameter DAT, 18, data width; SHALL be an integer multiple of BW.
REQ-003 Parameter BW, 9, byte-lane width; NB = DAT/BW lanes.
REQ-004 Parameter DEP, 256, word count, 2 <= DEP <= 2**ADR.
REQ-005 Parameter DEL, 1, read latency in cycles, legal 1..3.
REQ-006 Parameter RDW_MODE, 0, same-port read-during-write mode: 0 read-first, 1 write-first, 2 no-change.
REQ-007 Parameter CLR_ON_RST, 1, 1 = clear every word to zero after reset.
REQ-008 clka  in  1  single clock for both ports, all logic on rising edge.
REQ-009 rstb  in  1  reset, synchronous, active-high.
REQ-010 adra/adrb  in  ADR  port A/B word address.
REQ-011 rena/renb  in  1  port A/B enable; no access when low.
REQ-012 wena/wenb  in  1  port A/B write qualifier, effective only with rena/renb.
REQ-013 bena/benb  in  NB  port A/B byte-lane write enables; bit i covers data bits [i*BW +: BW].
REQ-014 wdaa/wdab  in  DAT  port A/B write data.
REQ-015 rdaa/rdab  out  DAT  port A/B read data.
REQ-016 vlda/vldb  out  1  port A/B read-data-valid strobe.
REQ-017 busy  out  1  clear sweep in progress; port requests ignored.
REQ-018 coll  out  1  one-cycle pulse: both ports wrote the same address in one cycle.

Function
REQ-019 Access at edge N when port enable is high, busy low and rstb low; vld for that access SHALL be high at edge N+DEL, with rd carrying its data.
REQ-020 rd SHALL hold its last value whenever vld is low.
REQ-021 Write SHALL update only lanes with ben bit set; ben=0 with wen=1 SHALL be a read with no memory change.
REQ-022 RDW_MODE 0 SHALL return the pre-write word; mode 1 SHALL return the post-write merged word; mode 2 SHALL leave rd unchanged and produce no vld pulse for that access.
REQ-023 Both ports writing the same address in one cycle: lanes enabled on both SHALL take port A data; lanes enabled only on B SHALL take port B data; coll SHALL pulse at the next edge.
REQ-024 One port writing while the other reads the same address: the reader SHALL return the pre-write word.
REQ-025 Address >= DEP SHALL be ignored for writes; the read SHALL return zero, with vld asserted normally.
REQ-026 Sweep FSM states: IDLE, CLEAR. rstb high forces CLEAR with pointer 0 when CLR_ON_RST=1, else IDLE.
REQ-027 CLEAR, rstb low: write zero to pointer address each cycle and increment; after writing DEP-1 go to IDLE; sweep lasts exactly DEP cycles after rstb falls.
REQ-028 busy SHALL be high in CLEAR and during rstb, low in IDLE.
REQ-029 Port enables SHALL be gated off while busy; accesses then produce no vld and no memory change.
REQ-030 The read pipeline SHALL be free-running; vld and rd SHALL not depend on a downstream enable.

Reset
REQ-031 While rstb is high: rdaa, rdab, vlda, vldb, coll SHALL be 0; busy SHALL be 1; in-flight pipeline entries SHALL be discarded.
REQ-032 rstb high mid-sweep SHALL restart the sweep from address 0.
REQ-033 With CLR_ON_RST=0, memory contents SHALL survive rstb; busy SHALL fall at the first edge after rstb falls.
REQ-034 Initial (power-up) contents SHALL be zero.

Verification (ADR=4, DAT=18, BW=9, DEP=16, DEL=2)
REQ-035 rstb 1 cycle, then idle -> busy high 16 cycles after rstb falls; then read of all 16 addresses returns 0x00000, each vld 2 cycles after request.
REQ-036 A writes 0x3FFFF to addr 5, bena=2'b01, over 0x00000 -> B read of addr 5 returns 0x001FF.
REQ-037 Same cycle, A writes 0x12345 to addr 3 with bena=11, B writes 0x2ABCD to addr 3 with benb=11 -> coll=1 next cycle; readback 0x12345.
REQ-038 RDW_MODE=0/1/2, addr 7 holds 0x00011, A writes 0x00022 -> rdaa 0x00011 / 0x00022 / unchanged with vlda=0.
REQ-039 rstb asserted at sweep cycle 8 -> busy stays high; sweep restarts at 0; completes 16 cycles after second rstb fall.
REQ-040 Back-to-back reads addr 0..15 on both ports every cycle -> continuous vld, correct data, no bubbles.
